// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: sequencer state encodings and the default
// address/instruction widths and reset PC used by mod_fetch_ctrl.
package fetch_pkg;

  localparam int          FETCH_ADDR_W   = 32;
  localparam int          FETCH_INSTR_W  = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/mod_fetch_ctrl_if.sv
// Instruction-memory port of the fetch stage: request/address out, ack/data back.
interface mod_fetch_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);

  // imem_req is held high with a fixed imem_addr until the cycle imem_ack is
  // seen; that cycle completes the access and imem_rdata is valid only then.
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/mod_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the PC mux select, runs the imem
// req/ack handshake and presents instructions to decode under stall.
module mod_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  input  logic [ADDR_W-1:0]  next_address,
  output logic               pc_sel,
  output logic [ADDR_W-1:0]  pc_plus_4,
  output logic [ADDR_W-1:0]  branch_address,
  mod_fetch_ctrl_if.master   imem,
  output logic               if_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  if_pc,
  output fetch_state_e       dbg_state
);

  // Decode consumes instr on a cycle where if_valid && !stall.

  fetch_state_e       state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic               redir_pend, redir_pend_n;
  logic [ADDR_W-1:0]  redir_addr, redir_addr_n;
  logic [INSTR_W-1:0] instr_q, instr_n;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_n;
  logic [ADDR_W-1:0]  target_aligned;
  logic               redirect_now;
  logic               req;

  assign target_aligned = branch_target & ~ADDR_W'(3);
  assign redirect_now   = redir_pend | branch_taken;
  assign pc_plus_4      = pc + ADDR_W'(4);

  // Forced to zero during reset so the mux sees a quiet input.
  assign branch_address = !rst_n     ? '0 :
                          redir_pend ? redir_addr : target_aligned;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign dbg_state      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      redir_pend <= 1'b0;
      redir_addr <= '0;
      instr_q    <= '0;
      if_pc_q    <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      redir_pend <= redir_pend_n;
      redir_addr <= redir_addr_n;
      instr_q    <= instr_n;
      if_pc_q    <= if_pc_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    redir_pend_n = redir_pend;
    redir_addr_n = redir_addr;
    instr_n      = instr_q;
    if_pc_n      = if_pc_q;
    req          = 1'b0;
    pc_sel       = 1'b0;
    if_valid     = 1'b0;
    instr        = instr_q;
    if_pc        = if_pc_q;

    case (state)
      S_IDLE: begin
        state_n = S_REQ;
      end

      S_REQ: begin
        req = 1'b1;
        if (imem.imem_ack) begin
          if (redirect_now) begin
            // Returning word belongs to the squashed path; drop it.
            pc_sel       = 1'b1;
            pc_n         = next_address;
            redir_pend_n = 1'b0;
          end else begin
            if_valid = 1'b1;
            instr    = imem.imem_rdata;
            if_pc    = pc;
            instr_n  = imem.imem_rdata;
            if_pc_n  = pc;
            if (stall) begin
              state_n = S_HOLD;
            end else begin
              pc_n = next_address;
            end
          end
        end else if (branch_taken) begin
          // Address must stay stable until ack, so park the redirect.
          redir_pend_n = 1'b1;
          redir_addr_n = target_aligned;
        end
      end

      S_HOLD: begin
        if_valid = 1'b1;
        if (branch_taken) begin
          pc_sel  = 1'b1;
          pc_n    = target_aligned;
          state_n = S_REQ;
        end else if (!stall) begin
          pc_n    = pc_plus_4;
          state_n = S_REQ;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mod_fetch_ctrl.sv
// Directed bench for mod_fetch_ctrl: per-cycle vector table plus reset sequences.
module tb_mod_fetch_ctrl;
  import fetch_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         branch_taken;
  logic [31:0]  branch_target;
  logic         stall;
  logic [31:0]  next_address;
  logic         pc_sel;
  logic [31:0]  pc_plus_4;
  logic [31:0]  branch_address;
  logic         if_valid;
  logic [31:0]  instr;
  logic [31:0]  if_pc;
  fetch_state_e dbg_state;

  int total;
  int bad;

  mod_fetch_ctrl_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  mod_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .next_address  (next_address),
    .pc_sel        (pc_sel),
    .pc_plus_4     (pc_plus_4),
    .branch_address(branch_address),
    .imem          (bus),
    .if_valid      (if_valid),
    .instr         (instr),
    .if_pc         (if_pc),
    .dbg_state     (dbg_state)
  );

  // External PC mux model.
  assign next_address = pc_sel ? branch_address : pc_plus_4;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        bt;
    logic [31:0] tgt;
    logic        stl;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        c_valid;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ifpc;
    logic        e_sel;
    logic        c_baddr;
    logic [31:0] e_baddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic bt, logic [31:0] tgt, logic stl, logic ack,
                              logic [31:0] rdata, logic e_req, logic [31:0] e_addr,
                              logic c_valid, logic e_valid, logic [31:0] e_instr,
                              logic [31:0] e_ifpc, logic e_sel, logic c_baddr,
                              logic [31:0] e_baddr);
    vec_t v;
    v.bt = bt; v.tgt = tgt; v.stl = stl; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.c_valid = c_valid; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_ifpc = e_ifpc; v.e_sel = e_sel;
    v.c_baddr = c_baddr; v.e_baddr = e_baddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic bt, input logic [31:0] tgt, input logic stl,
                       input logic ack, input logic [31:0] rdata);
    branch_taken   = bt;
    branch_target  = tgt;
    stall          = stl;
    bus.imem_ack   = ack;
    bus.imem_rdata = rdata;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b1, 32'h500, 1'b0, 1'b1, 32'hBAD0_BAD0);

    // idle / burst of acks: addresses 0,4,8,C,C
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 32'h0,  1, 0, 0, 0, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hA0,       1, 32'h0,  1, 1, 32'hA0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hA1,       1, 32'h4,  1, 1, 32'hA1, 32'h4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hA2,       1, 32'h8,  1, 1, 32'hA2, 32'h8, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 32'hC,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hA3,       1, 32'hC,  1, 1, 32'hA3, 32'hC, 0, 0, 0));
    // ack under stall, held in HOLD for 3 cycles, resume at pc+4
    vecs.push_back(mk(0, 0, 1, 1, 32'hA4,       1, 32'h10, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0,            0, 32'h10, 1, 1, 32'hA4, 32'h10, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0,            0, 32'h10, 1, 1, 32'hA4, 32'h10, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0,            0, 32'h10, 1, 1, 32'hA4, 32'h10, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 32'h10, 1, 1, 32'hA4, 32'h10, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 32'h14, 1, 0, 0, 0, 0, 0, 0));
    // branch while access outstanding: address held, data dropped, then 0x100
    vecs.push_back(mk(1, 32'h100, 0, 0, 0,      1, 32'h14, 1, 0, 0, 0, 0, 1, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 32'h14, 1, 0, 0, 0, 0, 1, 32'h100));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDEAD,     1, 32'h14, 1, 0, 0, 0, 1, 1, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 32'h100, 1, 0, 0, 0, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hB0,       1, 32'h100, 1, 1, 32'hB0, 32'h100, 0, 0, 0));
    // branch coincident with ack, unaligned target
    vecs.push_back(mk(1, 32'h203, 0, 1, 32'hDEAD2, 1, 32'h104, 1, 0, 0, 0, 1, 1, 32'h200));
    vecs.push_back(mk(0, 0, 0, 1, 32'hB1,       1, 32'h200, 1, 1, 32'hB1, 32'h200, 0, 0, 0));
    // branch while holding a stalled instruction
    vecs.push_back(mk(0, 0, 1, 1, 32'hB2,       1, 32'h204, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h300, 1, 0, 0,      0, 32'h204, 1, 1, 32'hB2, 32'h204, 1, 1, 32'h300));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 32'h300, 1, 0, 0, 0, 0, 0, 0));
    // reach top of address space and wrap
    vecs.push_back(mk(1, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'h300, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDEAD3,    1, 32'h300, 1, 0, 0, 0, 1, 1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, 0, 1, 32'hC0,       1, 32'hFFFF_FFFC, 1, 1, 32'hC0, 32'hFFFF_FFFC, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 32'h0,  1, 0, 0, 0, 0, 0, 0));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ifpc",  if_pc, 32'h0);
    chk("rst_sel",   {31'b0, pc_sel}, 32'd0);
    chk("rst_baddr", branch_address, 32'h0);

    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].bt, vecs[i].tgt, vecs[i].stl, vecs[i].ack, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i),  {31'b0, bus.imem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_pc4", i),  pc_plus_4, vecs[i].e_addr + 32'd4);
      chk($sformatf("v%0d_sel", i),  {31'b0, pc_sel}, {31'b0, vecs[i].e_sel});
      if (vecs[i].c_valid)
        chk($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].c_valid && vecs[i].e_valid) begin
        chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
        chk($sformatf("v%0d_ifpc", i),  if_pc, vecs[i].e_ifpc);
      end
      if (vecs[i].c_baddr)
        chk($sformatf("v%0d_baddr", i), branch_address, vecs[i].e_baddr);
      @(negedge clk);
    end

    // reset asserted mid-request: pending ack ignored, restart at RESET_PC
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hC1);
    #1;
    chk("pre_valid", {31'b0, if_valid}, 32'd1);
    chk("pre_instr", instr, 32'hC1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("pre_addr", bus.imem_addr, 32'h4);
    rst_n = 1'b0;
    drive(1'b1, 32'h500, 1'b0, 1'b1, 32'hBAD1);
    #1;
    chk("mid_rst_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("mid_rst_addr",  bus.imem_addr, 32'h0);
    chk("mid_rst_valid", {31'b0, if_valid}, 32'd0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_baddr", branch_address, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rel_req",  {31'b0, bus.imem_req}, 32'd0);
    chk("rel_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hD0);
    #1;
    chk("restart_req",   {31'b0, bus.imem_req}, 32'd1);
    chk("restart_addr",  bus.imem_addr, 32'h0);
    chk("restart_valid", {31'b0, if_valid}, 32'd1);
    chk("restart_instr", instr, 32'hD0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("restart_next", bus.imem_addr, 32'h4);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
